// File: rtl/lsu_dmem.sv
// RV32I load/store unit for a word-only data RAM; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests answer with resp_err_o instead of being force-aligned.
module lsu_dmem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_err_o,
   output logic [ADDR_WIDTH-1:0] dmem_addr_o,
   inout  wire logic [DATA_WIDTH-1:0] dmem_data_io,
   output logic                  dmem_wen_o
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WR   = 3'd2;
   localparam logic [2:0] S_RESP = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   // Unsupported encodings behave as a word access.
   function automatic logic [2:0] norm_f3(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: norm_f3 = f3;
         default:                                 norm_f3 = 3'b010;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b01:   misaligned = a[0];
         2'b10:   misaligned = (a != 2'b00);
         default: misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  extract = {{24{b[7]}}, b};
         3'b001:  extract = {{16{h[15]}}, h};
         3'b100:  extract = {24'd0, b};
         3'b101:  extract = {16'd0, h};
         default: extract = w;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] lane,
                                         input logic [31:0] old_w, input logic [31:0] wd);
      logic [31:0] m;
      m = old_w;
      case (f3[1:0])
         2'b00: m[{lane, 3'b000} +: 8] = wd[7:0];
         2'b01: begin
            if (lane[1]) begin
               m[31:16] = wd[15:0];
            end else begin
               m[15:0] = wd[15:0];
            end
         end
         default: m = wd;
      endcase
      merge = m;
   endfunction

   logic [2:0]            state_q, state_d;
   logic                  we_q, we_d;
   logic [2:0]            f3_q, f3_d;
   logic [1:0]            lane_q, lane_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] wword_q, wword_d;
   logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
   logic                  wen_q, wen_d;
   logic                  ready_q, ready_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rerr_q, rerr_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic [2:0]            req_f3_s;
   logic                  req_mis_s;
   logic [ADDR_WIDTH-1:0] req_addr_s;

   // Request decode: normalise funct3 and, without trapping, force-align the address.
   always_comb begin
      req_f3_s   = norm_f3(req_funct3_i);
      req_mis_s  = misaligned(req_f3_s, req_addr_i[1:0]);
      req_addr_s = req_addr_i;
`ifndef LSU_MISALIGN_TRAP_EN
      if (req_f3_s[1:0] == 2'b01) begin
         req_addr_s[0] = 1'b0;
      end else if (req_f3_s[1:0] == 2'b10) begin
         req_addr_s[1:0] = 2'b00;
      end else begin
         req_addr_s = req_addr_i;
      end
`endif
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      f3_d     = f3_q;
      lane_d   = lane_q;
      wdata_d  = wdata_q;
      wword_d  = wword_q;
      daddr_d  = daddr_q;
      wen_d    = 1'b0;
      rvalid_d = 1'b0;
      rerr_d   = 1'b0;
      rdata_d  = {DATA_WIDTH{1'b0}};
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               we_d    = req_we_i;
               f3_d    = req_f3_s;
               lane_d  = req_addr_s[1:0];
               wdata_d = req_wdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
               if (req_mis_s) begin
                  state_d  = S_ERR;
                  rvalid_d = 1'b1;
                  rerr_d   = 1'b1;
               end else
`endif
               if (req_we_i && (req_f3_s[1:0] == 2'b10)) begin
                  state_d = S_WR;
                  daddr_d = {req_addr_s[ADDR_WIDTH-1:2], 2'b00};
                  wen_d   = 1'b1;
                  wword_d = req_wdata_i;
               end else begin
                  state_d = S_RD;
                  daddr_d = {req_addr_s[ADDR_WIDTH-1:2], 2'b00};
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         // RAM read is combinational, so the word is consumed in the same cycle.
         S_RD: begin
            if (we_q) begin
               state_d = S_WR;
               wen_d   = 1'b1;
               wword_d = merge(f3_q, lane_q, dmem_data_io, wdata_q);
            end else begin
               state_d  = S_RESP;
               rvalid_d = 1'b1;
               rdata_d  = extract(f3_q, lane_q, dmem_data_io);
            end
         end
         S_WR: begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
         end
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         f3_q     <= 3'b000;
         lane_q   <= 2'b00;
         wdata_q  <= {DATA_WIDTH{1'b0}};
         wword_q  <= {DATA_WIDTH{1'b0}};
         daddr_q  <= {ADDR_WIDTH{1'b0}};
         wen_q    <= 1'b0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
         rdata_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         f3_q     <= f3_d;
         lane_q   <= lane_d;
         wdata_q  <= wdata_d;
         wword_q  <= wword_d;
         daddr_q  <= daddr_d;
         wen_q    <= wen_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
         rdata_q  <= rdata_d;
      end
   end

   // Reset during WR must not let the pending write land in the RAM.
   assign dmem_wen_o   = wen_q & ~rst_i;
   assign dmem_data_io = dmem_wen_o ? wword_q : {DATA_WIDTH{1'bz}};
   assign dmem_addr_o  = daddr_q;
   assign req_ready_o  = ready_q;
   assign resp_valid_o = rvalid_q;
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = rerr_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed self-checking bench for lsu_dmem with a small word-addressed RAM model.
module tb_lsu_dmem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] dmem_addr;
   wire  [31:0] dmem_data;
   logic        dmem_wen;

   logic [31:0] mem [0:63];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsu_dmem dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_we_i     (req_we),
      .req_funct3_i (req_funct3),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .resp_valid_o (resp_valid),
      .resp_rdata_o (resp_rdata),
      .resp_err_o   (resp_err),
      .dmem_addr_o  (dmem_addr),
      .dmem_data_io (dmem_data),
      .dmem_wen_o   (dmem_wen)
   );

   assign dmem_data = dmem_wen ? 32'bz : mem[dmem_addr[7:2]];

   always @(posedge clk) begin
      if (dmem_wen) mem[dmem_addr[7:2]] <= dmem_data;
   end

   // One request; observes latency (edges to resp_valid), response and write activity.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output int wcnt, output logic [31:0] waddr);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = -1; rd = 32'd0; er = 1'b0; wcnt = 0; waddr = 32'd0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (dmem_wen) begin
            wcnt++;
            waddr = dmem_addr;
         end
         if (resp_valid) begin
            lat = i; rd = resp_rdata; er = resp_err;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", resp_valid); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", resp_err); end
      checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
      checks++; if (dmem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %0b want 0", dmem_wen); end
      checks++; if (dmem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h want 0", dmem_addr); end
      rst = 1'b0;
   endtask

   task automatic test_sw_lw;
      int lat, wc; logic [31:0] rd, wa; logic er;
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er, wc, wa);
      checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d want 2", lat); end
      checks++; if (wc !== 1) begin errors++; $display("FAIL sw_wen_cycles got %0d want 1", wc); end
      checks++; if (wa !== 32'h10) begin errors++; $display("FAIL sw_addr got %h want 00000010", wa); end
      checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_word got %h want deadbeef", mem[4]); end
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL sw_rdata got %h want 0", rd); end
      do_req(1'b0, 3'b010, 32'h10, 32'd0, lat, rd, er, wc, wa);
      checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d want 2", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", rd); end
      checks++; if (wc !== 0) begin errors++; $display("FAIL lw_wen got %0d want 0", wc); end
   endtask

   task automatic test_load_bytes;
      int lat, wc; logic [31:0] rd, wa; logic er;
      logic [2:0]  f3v [5]  = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000};
      logic [31:0] av  [5]  = '{32'h10, 32'h11, 32'h13, 32'h13, 32'h12};
      logic [31:0] ev  [5]  = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFFFF80, 32'h00000080, 32'hFFFFFF81};
      mem[4] = 32'h80817F80;
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, f3v[i], av[i], 32'd0, lat, rd, er, wc, wa);
         checks++; if (rd !== ev[i] || lat !== 2) begin
            errors++; $display("FAIL load_byte[%0d] got %h lat %0d want %h lat 2", i, rd, lat, ev[i]);
         end
      end
   endtask

   task automatic test_sb;
      int lat, wc; logic [31:0] rd, wa; logic er;
      mem[8] = 32'h11223344;
      do_req(1'b1, 3'b000, 32'h22, 32'h123456AA, lat, rd, er, wc, wa);
      checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency got %0d want 3", lat); end
      checks++; if (wc !== 1) begin errors++; $display("FAIL sb_wen_cycles got %0d want 1", wc); end
      checks++; if (mem[8] !== 32'h11AA3344) begin errors++; $display("FAIL sb_word got %h want 11aa3344", mem[8]); end
   endtask

   task automatic test_sh_lh;
      int lat, wc; logic [31:0] rd, wa; logic er;
      mem[8] = 32'h11223344;
      do_req(1'b1, 3'b001, 32'h22, 32'h0000BEEF, lat, rd, er, wc, wa);
      checks++; if (lat !== 3) begin errors++; $display("FAIL sh_latency got %0d want 3", lat); end
      checks++; if (mem[8] !== 32'hBEEF3344) begin errors++; $display("FAIL sh_word got %h want beef3344", mem[8]); end
      do_req(1'b0, 3'b001, 32'h22, 32'd0, lat, rd, er, wc, wa);
      checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_data got %h want ffffbeef", rd); end
      do_req(1'b0, 3'b101, 32'h22, 32'd0, lat, rd, er, wc, wa);
      checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_data got %h want 0000beef", rd); end
      do_req(1'b0, 3'b101, 32'h20, 32'd0, lat, rd, er, wc, wa);
      checks++; if (rd !== 32'h00003344) begin errors++; $display("FAIL lhu_low got %h want 00003344", rd); end
   endtask

   task automatic test_misalign;
      int lat, wc; logic [31:0] rd, wa; logic er;
      mem[4] = 32'hCAFEF00D;
      do_req(1'b0, 3'b010, 32'h12, 32'd0, lat, rd, er, wc, wa);
`ifdef LSU_MISALIGN_TRAP_EN
      checks++; if (lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL misalign_trap got lat %0d err %0b want lat 1 err 1", lat, er); end
      checks++; if (rd !== 32'd0 || wc !== 0) begin errors++; $display("FAIL misalign_trap_side got rdata %h wen %0d want 0 0", rd, wc); end
`else
      checks++; if (lat !== 2 || er !== 1'b0) begin errors++; $display("FAIL misalign_fix got lat %0d err %0b want lat 2 err 0", lat, er); end
      checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL misalign_fix_data got %h want cafef00d", rd); end
`endif
   endtask

   task automatic test_reset_mid_store;
      int lat, wc; logic [31:0] rd, wa; logic er;
      mem[8] = 32'h11223344;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'h55;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (dmem_wen !== 1'b1) begin errors++; $display("FAIL rmw_in_wr got wen %0b want 1", dmem_wen); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_abort got valid %0b ready %0b want 0 1", resp_valid, req_ready);
      end
      checks++; if (mem[8] !== 32'h11223344) begin errors++; $display("FAIL reset_abort_word got %h want 11223344", mem[8]); end
      rst = 1'b0;
      do_req(1'b0, 3'b010, 32'h20, 32'd0, lat, rd, er, wc, wa);
      checks++; if (rd !== 32'h11223344 || lat !== 2) begin
         errors++; $display("FAIL post_reset_lw got %h lat %0d want 11223344 lat 2", rd, lat);
      end
   endtask

   task automatic test_back_to_back;
      logic [5:0] rv_pat, rdy_pat;
      rv_pat = 6'd0; rdy_pat = 6'd0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         rv_pat[i-1]  = resp_valid;
         rdy_pat[i-1] = req_ready;
         if (i == 5) req_valid = 1'b0;
      end
      checks++; if (rv_pat !== 6'b010010) begin errors++; $display("FAIL b2b_valid got %b want 010010", rv_pat); end
      checks++; if (rdy_pat !== 6'b100100) begin errors++; $display("FAIL b2b_ready got %b want 100100", rdy_pat); end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      test_reset;
      test_sw_lw;
      test_load_bytes;
      test_sb;
      test_sh_lh;
      test_misalign;
      test_reset_mid_store;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_dmem.md
# lsu_dmem

Load/store unit that initiates accesses on the data-memory port (`dmem_addr`, `dmem_data`, `dmem_wen`) on behalf of the CPU's memory stage. It accepts one RV32I load or store request at a time and returns sign- or zero-extended load data or a store completion. The data RAM supports word writes only, so byte and halfword stores are performed as a read-modify-write sequence. It sits between the pipeline's MEM stage and the word-addressed `ram` responder.

## Interface
- `addr_width`, 32, width of `req_addr` and `dmem_addr`.
- `data_width`, 32, word width; fixed at 32 for the sub-word lane logic.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request transfers when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  addr_width  byte address.
- `req_wdata`  in  32  store data; the value is taken from the low lanes.
- `resp_valid`  out  1  one-cycle pulse; the operation is complete.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `resp_err`  out  1  misaligned access, qualified by `resp_valid`.
- `dmem_addr`  out  addr_width  word-aligned address; bits [1:0] are always 00.
- `dmem_data`  inout  32  driven by the LSU only while `dmem_wen`=1, high-Z otherwise.
- `dmem_wen`  out  1  word write strobe; the RAM writes on the rising edge where it is high.

## Operation
- The RAM read is combinational: `dmem_data` is valid in the same cycle `dmem_addr` is presented.
- The accepted request is latched: we, funct3, addr, wdata.
- Misalignment rule: H/HU with addr[0]=1, or W with addr[1:0]≠0.
- Illegal funct3 (011, 110, 111) is treated as W.
- States:
  - IDLE: go to ERR if misaligned (with the macro defined). Otherwise go to RD for loads and for sub-word stores; go to WR for SW.
  - RD: drive `dmem_addr`, register `dmem_data` into `rword`. Loads go to RESP; stores go to WR.
  - WR: drive `dmem_addr`, `dmem_wen`=1, and `dmem_data` = merged word.
    - SW: merged word = wdata.
    - SB: merged word = rword with lane addr[1:0] replaced by wdata[7:0].
    - SH: merged word = rword with lane addr[1] replaced by wdata[15:0].
    - Next state RESP.
  - RESP: assert `resp_valid`; for loads, `resp_rdata` = extracted lane. Next state IDLE.
  - ERR: assert `resp_valid` and `resp_err`=1; `resp_rdata`=0. Next state IDLE.
- Load extraction:
  - B/H sign-extend bit 7/15 of the selected lane.
  - BU/HU zero-extend.
  - W passes the word through.
- Idle values: `dmem_addr` holds the last value; `dmem_wen`=0.

## Timing
- Reset (synchronous, `rst`=1 at an edge):
  - State returns to IDLE; any operation in flight is abandoned, with no write and no response.
  - Outputs: `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `dmem_wen`=0, `dmem_addr`=0, `dmem_data` high-Z.
- Request accepted at edge 0; latency is counted in edges to the `resp_valid` cycle.
  - Load: RD in cycle 1, `resp_valid` in cycle 2.
  - SW: WR in cycle 1, `resp_valid` in cycle 2.
  - SB/SH: RD in cycle 1, WR in cycle 2, `resp_valid` in cycle 3.
  - Misaligned (macro defined): ERR in cycle 1 with no memory access.
- `req_ready` returns high in the cycle after RESP/ERR, so back-to-back throughput is one request per 3 cycles for loads/SW and 4 for SB/SH.
- `req_valid` while `req_ready`=0 is ignored; the requester holds it.
- `dmem_wen` is high for exactly one cycle per store.

## Configuration
- `LSU_MISALIGN_TRAP_EN`
  - Defined: misaligned requests go to ERR, `resp_err`=1, and no RAM access occurs.
  - Undefined: no ERR state; the offending low address bits are cleared (H: bit 0; W: bits 1:0), the access proceeds normally, and `resp_err` is tied 0.

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> `dmem_wen` high one cycle at `dmem_addr` 0x10; LW `resp_rdata`=0xDEADBEEF two cycles after acceptance.
- Word 0x10 = 0x8081_7F80; issue LB at 0x10, 0x11, 0x13 and LBU at 0x13 -> responses 0xFFFFFF80, 0x0000007F, 0xFFFFFF80, 0x00000080.
- Word 0x20 = 0x11223344, SB 0x22 data 0xAA -> RD then WR; word becomes 0x11AA3344; `resp_valid` in cycle 3.
- Word 0x20 = 0x11223344, SH 0x22 data 0xBEEF -> word 0xBEEF3344. Then LH 0x22 -> 0xFFFFBEEF; LHU -> 0x0000BEEF.
- LW 0x12 with the macro defined -> `resp_valid` and `resp_err`=1 in cycle 1, no `dmem_wen`. Without the macro -> reads word 0x10, `resp_err`=0.
- Assert `rst` during WR of an SB -> no `resp_valid`, `req_ready`=1 the next cycle; a new LW then completes correctly.
